// File: rtl/aes_ctrl_pkg.sv
// aes_ctrl_pkg: shared state encoding, beat types and watchdog limit for the AES controller
package aes_ctrl_pkg;
    typedef enum logic [2:0] {
        IDLE, COLLECT, CHG_KEY, KEY_WAIT, PREADD, LOAD, DRAIN, ERROR
    } state_t;
    localparam logic KEY_T = 1'b0;
    localparam logic DATA_T = 1'b1;
    localparam logic [15:0] WD_LIMIT = 16'hFFFF;
endpackage

// File: rtl/aes_pipe_ctrl_if.sv
// aes_pipe_ctrl_if: handshake bundle between the AES controller and its interface/pipeline
interface aes_pipe_ctrl_if #(parameter int PIPE_DEPTH = 10);
    logic start, stop, enc_dec, data_received, data_type, chg_key_done, data_output, wr_ready;
    logic fetch, load_key, done_chg_key, preaddkey, aes_load, aes_enable, ahb_mode;
    logic dec_mode, busy, error;
    logic [$clog2(PIPE_DEPTH+1)-1:0] inflight;
    modport master (
        input  start, stop, enc_dec, data_received, data_type, chg_key_done, data_output, wr_ready,
        output fetch, load_key, done_chg_key, preaddkey, aes_load, aes_enable, ahb_mode,
               dec_mode, busy, error, inflight
    );
    modport slave (
        output start, stop, enc_dec, data_received, data_type, chg_key_done, data_output, wr_ready,
        input  fetch, load_key, done_chg_key, preaddkey, aes_load, aes_enable, ahb_mode,
               dec_mode, busy, error, inflight
    );
endinterface

// File: rtl/aes_inflight_cnt.sv
// aes_inflight_cnt: saturating count of blocks in the round pipeline
module aes_inflight_cnt #(
    parameter int MAX = 10,
    parameter int W = $clog2(MAX+1)
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         inc_i,
    input  logic         dec_i,
    input  logic         clear_i,
    output logic [W-1:0] cnt_o,
    output logic         full_o,
    output logic         empty_o,
    output logic         underflow_o
);
    logic [W-1:0] cnt_q;
    assign cnt_o = cnt_q;
    assign full_o = cnt_q == W'(MAX);
    assign empty_o = cnt_q == '0;
    assign underflow_o = dec_i && empty_o;
    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) cnt_q <= '0;
        else if (clear_i) cnt_q <= '0;
        else if (inc_i && !dec_i && !full_o) cnt_q <= cnt_q + 1'b1;
        else if (dec_i && !inc_i && !empty_o) cnt_q <= cnt_q - 1'b1;
endmodule

// File: rtl/flex_counter.sv
// flex_counter: clearable up counter that wraps to 0 after rollover_val
module flex_counter #(parameter int NUM_CNT_BITS = 4) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag
);
    assign rollover_flag = count_out == rollover_val;
    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) count_out <= '0;
        else if (clear) count_out <= '0;
        else if (count_enable) count_out <= rollover_flag ? '0 : count_out + 1'b1;
endmodule

// File: rtl/aes_pipe_ctrl.sv
// aes_pipe_ctrl: sequences key loads and data blocks into the AES round pipeline
// Optional AES_CTRL_WATCHDOG_EN adds a 16-bit stall watchdog in KEY_WAIT and DRAIN.
module aes_pipe_ctrl
    import aes_ctrl_pkg::*;
#(
    parameter int PIPE_DEPTH = 10,
    parameter int BLOCK_BEATS = 4,
    parameter int KEY_BEATS = 4
) (
    input logic clk,
    input logic n_rst,
    aes_pipe_ctrl_if.master bus
);
    localparam int W = $clog2(PIPE_DEPTH+1);
    localparam int CW = $clog2((KEY_BEATS > BLOCK_BEATS ? KEY_BEATS : BLOCK_BEATS) + 1);
    state_t state_q, state_d;
    logic dec_mode_q, type_q, done_q;
    logic [CW-1:0] beat_cnt, roll_val;
    logic [W-1:0] inflight;
    logic at_roll, full, empty, uf, active, first, cur_type, last, xfer, load;
    logic err_uf, err_type, err_key;

    assign active = state_q != IDLE && state_q != ERROR;
    assign xfer = active && bus.data_output && bus.wr_ready;
    assign first = beat_cnt == '0;
    // the first beat fixes the type, so its own data_type selects the beat target
    assign cur_type = first ? bus.data_type : type_q;
    assign roll_val = cur_type == KEY_T ? CW'(KEY_BEATS-1) : CW'(BLOCK_BEATS-1);
    assign last = bus.data_received && at_roll;
    assign load = state_q == LOAD && (!full || xfer);
    assign err_uf = uf || (active && bus.data_output && !bus.wr_ready && empty);
    assign err_type = bus.data_received && !first && bus.data_type != type_q;
    assign err_key = bus.data_received && first && bus.data_type == KEY_T && !empty;

    flex_counter #(.NUM_CNT_BITS(CW)) u_beat (
        .clk(clk), .n_rst(n_rst), .clear(state_q != COLLECT),
        .count_enable(state_q == COLLECT && bus.data_received),
        .rollover_val(roll_val), .count_out(beat_cnt), .rollover_flag(at_roll)
    );

    aes_inflight_cnt #(.MAX(PIPE_DEPTH), .W(W)) u_inflight (
        .clk(clk), .n_rst(n_rst), .inc_i(load), .dec_i(xfer),
        .clear_i(state_q == ERROR && bus.start), .cnt_o(inflight),
        .full_o(full), .empty_o(empty), .underflow_o(uf)
    );

`ifdef AES_CTRL_WATCHDOG_EN
    logic [15:0] wd_q;
    logic waiting;
    assign waiting = state_q == KEY_WAIT || state_q == DRAIN;
    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) wd_q <= '0;
        else wd_q <= (waiting && !xfer) ? wd_q + 16'd1 : '0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (bus.start) state_d = COLLECT;
            COLLECT:  if (err_type || err_key) state_d = ERROR;
                      else if (last) state_d = cur_type == KEY_T ? CHG_KEY : PREADD;
                      else if (bus.stop && first && !bus.data_received) state_d = DRAIN;
            CHG_KEY:  state_d = KEY_WAIT;
            KEY_WAIT: if (bus.chg_key_done) state_d = COLLECT;
            PREADD:   state_d = LOAD;
            LOAD:     if (load) state_d = COLLECT;
            DRAIN:    if (empty) state_d = IDLE;
            ERROR:    if (bus.start) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        if (active && err_uf) state_d = ERROR;
`ifdef AES_CTRL_WATCHDOG_EN
        if (waiting && wd_q == WD_LIMIT) state_d = ERROR;
`endif
    end

    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) begin
            state_q <= IDLE;
            dec_mode_q <= 1'b0;
            type_q <= KEY_T;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q <= state_q == KEY_WAIT && state_d == COLLECT;
            if (state_q == IDLE && bus.start) dec_mode_q <= bus.enc_dec;
            if (state_q == COLLECT && bus.data_received && first) type_q <= bus.data_type;
        end

    assign bus.fetch = state_q == COLLECT && !full;
    assign bus.load_key = state_q == CHG_KEY;
    assign bus.done_chg_key = done_q;
    assign bus.preaddkey = state_q == PREADD;
    assign bus.aes_load = load;
    assign bus.aes_enable = active && !(bus.data_output && !bus.wr_ready);
    assign bus.ahb_mode = xfer;
    assign bus.dec_mode = dec_mode_q;
    assign bus.busy = state_q != IDLE;
    assign bus.error = state_q == ERROR;
    assign bus.inflight = inflight;
endmodule

// File: tb/tb_aes_pipe_ctrl.sv
// tb_aes_pipe_ctrl: directed checks of aes_pipe_ctrl with PIPE_DEPTH=2 and 4-beat keys/blocks
module tb_aes_pipe_ctrl;
    logic clk = 1'b0;
    logic n_rst = 1'b0;
    int pass_cnt = 0;
    int total = 0;

    always #5 clk = ~clk;

    aes_pipe_ctrl_if #(.PIPE_DEPTH(2)) bus ();
    aes_pipe_ctrl #(.PIPE_DEPTH(2), .BLOCK_BEATS(4), .KEY_BEATS(4)) dut (
        .clk(clk), .n_rst(n_rst), .bus(bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beats(input logic t, input int n);
        for (int i = 0; i < n; i++) begin
            bus.data_received = 1'b1;
            bus.data_type = t;
            tick();
        end
        bus.data_received = 1'b0;
        #1;
    endtask

    task automatic block();
        beats(1'b1, 4);
        tick();
        tick();
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        #1;
    endtask

    initial begin
        bus.start = 0; bus.stop = 0; bus.enc_dec = 0; bus.data_received = 0;
        bus.data_type = 0; bus.chg_key_done = 0; bus.data_output = 0; bus.wr_ready = 0;
        #2;
        chk("rst_busy", bus.busy, 0);
        chk("rst_error", bus.error, 0);
        chk("rst_inflight", bus.inflight, 0);
        chk("rst_dec_mode", bus.dec_mode, 0);
        chk("rst_fetch", bus.fetch, 0);
        chk("rst_enable", bus.aes_enable, 0);
        tick();
        n_rst = 1'b1;
        pulse_start();
        chk("open_busy", bus.busy, 1);
        chk("open_fetch", bus.fetch, 1);
        chk("open_dec_mode", bus.dec_mode, 0);

        beats(1'b0, 4);
        chk("key_load_n1", bus.load_key, 1);
        tick();
        chk("key_load_n2", bus.load_key, 0);
        chk("key_wait_fetch", bus.fetch, 0);
        tick();
        tick();
        bus.chg_key_done = 1'b1;
        #1;
        chk("key_done_n4", bus.done_chg_key, 0);
        tick();
        bus.chg_key_done = 1'b0;
        #1;
        chk("key_done_n5", bus.done_chg_key, 1);
        chk("key_back_collect", bus.fetch, 1);
        tick();
        chk("key_done_once", bus.done_chg_key, 0);

        beats(1'b1, 4);
        chk("blk_preadd", bus.preaddkey, 1);
        chk("blk_preadd_noload", bus.aes_load, 0);
        tick();
        chk("blk_load", bus.aes_load, 1);
        chk("blk_load_pre_cnt", bus.inflight, 0);
        tick();
        chk("blk_inflight1", bus.inflight, 1);
        chk("blk_collect_fetch", bus.fetch, 1);
        bus.data_output = 1'b1; bus.wr_ready = 1'b1;
        #1;
        chk("blk_ahb_mode", bus.ahb_mode, 1);
        tick();
        bus.data_output = 1'b0;
        #1;
        chk("blk_ahb_once", bus.ahb_mode, 0);
        chk("blk_inflight0", bus.inflight, 0);

        bus.wr_ready = 1'b0;
        block();
        block();
        chk("bp_inflight2", bus.inflight, 2);
        chk("bp_fetch_low", bus.fetch, 0);
        bus.data_output = 1'b1;
        #1;
        chk("bp_enable_low", bus.aes_enable, 0);
        chk("bp_no_xfer", bus.ahb_mode, 0);
        tick();
        chk("bp_hold_cnt", bus.inflight, 2);
        bus.wr_ready = 1'b1;
        #1;
        chk("bp_enable_back", bus.aes_enable, 1);
        chk("bp_xfer", bus.ahb_mode, 1);
        tick();
        bus.data_output = 1'b0; bus.wr_ready = 1'b0;
        #1;
        chk("bp_inflight1", bus.inflight, 1);
        chk("bp_fetch_back", bus.fetch, 1);

        block();
        chk("sim_full", bus.inflight, 2);
        beats(1'b1, 4);
        tick();
        chk("sim_load_held", bus.aes_load, 0);
        tick();
        chk("sim_load_still_held", bus.aes_load, 0);
        bus.data_output = 1'b1; bus.wr_ready = 1'b1;
        #1;
        chk("sim_load_with_xfer", bus.aes_load, 1);
        chk("sim_xfer", bus.ahb_mode, 1);
        tick();
        bus.data_output = 1'b0;
        #1;
        chk("sim_inflight_2to2", bus.inflight, 2);
        bus.data_output = 1'b1;
        tick();
        bus.data_output = 1'b0;
        #1;
        chk("drain_pre_cnt", bus.inflight, 1);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        #1;
        chk("drain_busy", bus.busy, 1);
        chk("drain_no_fetch", bus.fetch, 0);
        chk("drain_enable", bus.aes_enable, 1);
        tick();
        chk("drain_wait", bus.busy, 1);
        bus.data_output = 1'b1;
        tick();
        bus.data_output = 1'b0; bus.wr_ready = 1'b0;
        #1;
        chk("drain_cnt0", bus.inflight, 0);
        chk("drain_still_busy", bus.busy, 1);
        tick();
        chk("drain_idle", bus.busy, 0);

        pulse_start();
        beats(1'b1, 1);
        beats(1'b0, 1);
        chk("err_type", bus.error, 1);
        chk("err_type_no_fetch", bus.fetch, 0);
        chk("err_type_no_enable", bus.aes_enable, 0);
        pulse_start();
        chk("err_clear_idle", bus.busy, 0);
        chk("err_clear_flag", bus.error, 0);

        pulse_start();
        block();
        beats(1'b0, 1);
        chk("err_key_inflight", bus.error, 1);
        chk("err_key_cnt_held", bus.inflight, 1);
        bus.data_output = 1'b1; bus.wr_ready = 1'b1;
        #1;
        chk("err_no_ahb", bus.ahb_mode, 0);
        bus.data_output = 1'b0; bus.wr_ready = 1'b0;
        pulse_start();
        chk("err_idle_cnt0", bus.inflight, 0);
        chk("err_idle", bus.busy, 0);

        pulse_start();
        bus.data_output = 1'b1;
        tick();
        bus.data_output = 1'b0;
        #1;
        chk("err_underflow", bus.error, 1);
        pulse_start();

        bus.enc_dec = 1'b1;
        pulse_start();
        bus.enc_dec = 1'b0;
        #1;
        chk("dec_mode", bus.dec_mode, 1);
        block();
        chk("dec_inflight1", bus.inflight, 1);
        n_rst = 1'b0;
        #1;
        chk("mid_rst_cnt", bus.inflight, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_dec", bus.dec_mode, 0);
        tick();
        n_rst = 1'b1;

`ifdef AES_CTRL_WATCHDOG_EN
        pulse_start();
        beats(1'b0, 4);
        begin
            int n = 0;
            while (!bus.error && n < 70000) begin
                tick();
                n++;
            end
            chk("wd_error", bus.error, 1);
            chk("wd_not_early", n >= 65535, 1);
        end
`endif

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/aes_pipe_ctrl.md
# aes_pipe_ctrl

Parametrised main controller for the AES accelerator datapath, sitting between the AHB-Lite slave interface and the key generator/round pipeline. Sequences key loads and data blocks, supports encrypt and decrypt sessions and configurable key and block beat counts, and keeps the round pipeline streaming with in-flight tracking and output backpressure.

## Interface
- PIPE_DEPTH, 10, maximum blocks in flight in the round pipeline (1..15)
- BLOCK_BEATS, 4, 32-bit AHB beats per data block
- KEY_BEATS, 4, 32-bit AHB beats per key (4/6/8 for AES-128/192/256)
- clk  in  1  clock
- n_rst  in  1  reset, asynchronous, active-low
- start  in  1  pulse: open a session (IDLE) or clear an error (ERROR)
- stop  in  1  level: finish the session after the pipeline drains
- enc_dec  in  1  0 = encrypt, 1 = decrypt; sampled when leaving IDLE
- data_received  in  1  one beat accepted by the interface this cycle
- data_type  in  1  beat type: 0 = key, 1 = data
- chg_key_done  in  1  key generator has stored the expanded key
- data_output  in  1  a block is valid at the pipeline exit
- wr_ready  in  1  interface can take the exiting block this cycle
- fetch  out  1  request the interface to fetch beats from SRAM
- load_key  out  1  one-cycle pulse to GenKey/preAddKey
- done_chg_key  out  1  one-cycle pulse to the interface
- preaddkey  out  1  initial AddRoundKey on the assembled block
- aes_load  out  1  push the block into the pipeline
- aes_enable  out  1  pipeline advance enable
- ahb_mode  out  1  output block is transferred this cycle
- dec_mode  out  1  registered session mode
- busy  out  1  state is not IDLE
- error  out  1  state is ERROR
- inflight  out  $clog2(PIPE_DEPTH+1)  blocks currently in the pipeline

## Operation
- States: IDLE, COLLECT, CHG_KEY, KEY_WAIT, PREADD, LOAD, DRAIN, ERROR.
- IDLE: start -> COLLECT. dec_mode <= enc_dec. Beat counter cleared.
- COLLECT: fetch = (inflight < PIPE_DEPTH). Each data_received increments the beat counter.
  - The first beat fixes the block type.
  - A later beat with a different data_type -> ERROR.
  - Last beat (KEY_BEATS for key, BLOCK_BEATS for data): key -> CHG_KEY, data -> PREADD. The beat counter clears.
  - First key beat while inflight != 0 -> ERROR.
  - stop with the beat counter at 0 -> DRAIN.
- CHG_KEY: load_key = 1 for one cycle -> KEY_WAIT.
- KEY_WAIT: on chg_key_done, pulse done_chg_key and go to COLLECT.
- PREADD: preaddkey = 1 for one cycle -> LOAD.
- LOAD: aes_load = 1 for one cycle. inflight increments -> COLLECT.
- DRAIN: go to IDLE when inflight == 0.
- ERROR: all strobes are 0. start -> IDLE; inflight and counters clear.
- aes_enable = (state is PREADD, LOAD, COLLECT, CHG_KEY, KEY_WAIT or DRAIN) and not (data_output and not wr_ready).
- ahb_mode = data_output and wr_ready in any non-IDLE, non-ERROR state. This transfer decrements inflight.
- Transfer and aes_load in the same cycle: inflight is unchanged.
- data_output while inflight == 0 -> ERROR (underflow).
- aes_load is never issued with inflight == PIPE_DEPTH. COLLECT withholds fetch at full.

## Timing
- All strobes decode from the registered state. aes_enable and ahb_mode additionally gate combinationally on data_output/wr_ready.
- Reset: state IDLE. All outputs 0; inflight 0; dec_mode 0.
- Data block, last beat at cycle N: preaddkey at N+1, aes_load at N+2, back in COLLECT at N+3.
- Key, last beat at N: load_key at N+1. done_chg_key one cycle after chg_key_done is seen high in KEY_WAIT.
- A reset assertion mid-operation discards in-flight tracking immediately.

## Configuration
- AES_CTRL_WATCHDOG_EN defined: a 16-bit counter runs in KEY_WAIT and in DRAIN. It reloads on state entry and on any transfer. Reaching 0xFFFF -> ERROR.
- AES_CTRL_WATCHDOG_EN undefined: no counter; KEY_WAIT and DRAIN wait indefinitely.

## Structure
- aes_ctrl_pkg holds the state enum, the type encodings (KEY_T = 0, DATA_T = 1) and the watchdog limit constant.
- Sub-module aes_inflight_cnt: saturating up/down counter with inc, dec and clear inputs, and full, empty and underflow outputs.
- The beat counter reuses the existing flex_counter.

## Test plan
- Key load, KEY_BEATS=4: 4 key beats -> load_key at N+1; chg_key_done at N+4 -> done_chg_key at N+5; state returns to COLLECT.
- Single block: 4 data beats -> preaddkey, then aes_load; inflight = 1; data_output with wr_ready high -> ahb_mode for 1 cycle, inflight = 0.
- Backpressure fill, PIPE_DEPTH=2: load 2 blocks with wr_ready = 0 -> fetch goes low and inflight = 2. Holding data_output high keeps aes_enable low. Raising wr_ready restores fetch.
- Simultaneous events: aes_load in the same cycle as a transfer -> inflight unchanged (2 -> 2). stop with 1 block in flight -> DRAIN, then IDLE after the transfer.
- Errors: type switch at beat 2 -> error = 1; key beat with inflight = 1 -> ERROR; start -> IDLE with inflight = 0.
- Decrypt session and watchdog (AES_CTRL_WATCHDOG_EN): enc_dec = 1 at start -> dec_mode = 1. chg_key_done withheld -> error after 65535 cycles.
